// File: rtl/lsu_mem_unit.sv
// lsu_mem_unit: load/store unit bridging a core valid/ready request to a
// word-addressed data memory with byte enables and a variable-latency ack.
// Loads return sign/zero-extended lanes; stores drive byte enables only.
// Optional feature macro: LSU_TIMEOUT_EN bounds the REQ wait to MAX_WAIT cycles.
module lsu_mem_unit #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              resp_valid,
  output logic [XLEN-1:0]   resp_rdata,
  output logic              resp_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [XLEN/8-1:0] mem_be,
  input  logic              mem_ack,
  input  logic [XLEN-1:0]   mem_rdata,
  output logic              busy
);

  localparam int unsigned BE_W  = XLEN / 8;
  localparam int unsigned OFF_W = $clog2(BE_W);

  if ((XLEN != 32 && XLEN != 64) || MAX_WAIT == 0) begin : g_bad_param
    $error("lsu_mem_unit: XLEN must be 32 or 64 and MAX_WAIT must be nonzero");
  end

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t              state_q, state_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [XLEN-1:0]     mem_wdata_q, mem_wdata_d;
  logic [BE_W-1:0]     mem_be_q, mem_be_d;
  logic                resp_valid_q, resp_valid_d;
  logic [XLEN-1:0]     resp_rdata_q, resp_rdata_d;
  logic                resp_err_q, resp_err_d;
  logic [2:0]          op_q, op_d;
  logic [OFF_W-1:0]    off_q, off_d;

  logic [OFF_W-1:0]    acc_off;
  logic                acc_illegal;
  logic                acc_misal;
  logic [BE_W-1:0]     acc_be;
  logic [XLEN-1:0]     acc_wdata;
  logic [XLEN-1:0]     lane;
  logic [XLEN-1:0]     load_data;

`ifdef LSU_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);
  logic [CNT_W-1:0]    cnt_q, cnt_d;
`endif

  assign req_ready  = (state_q == IDLE) && !rst;
  assign busy       = (state_q != IDLE) && !rst;
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_be     = mem_be_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

  // Decode the presented request: legality, alignment, lane enables, replicated data
  always_comb begin
    acc_off     = req_addr[OFF_W-1:0];
    acc_illegal = 1'b0;
    acc_misal   = 1'b0;
    acc_be      = '0;
    acc_wdata   = req_wdata;
    if (req_op == 3'b111) acc_illegal = 1'b1;
    if (XLEN == 32 && (req_op == 3'b011 || req_op == 3'b110)) acc_illegal = 1'b1;
    if (req_we && req_op[2]) acc_illegal = 1'b1;
    unique case (req_op[1:0])
      2'b00: begin
        acc_be    = BE_W'(1) << acc_off;
        acc_wdata = {BE_W{req_wdata[7:0]}};
      end
      2'b01: begin
        acc_misal = req_addr[0];
        acc_be    = BE_W'(3) << acc_off;
        acc_wdata = {(XLEN/16){req_wdata[15:0]}};
      end
      2'b10: begin
        acc_misal = |req_addr[1:0];
        acc_be    = BE_W'(15) << acc_off;
        acc_wdata = {(XLEN/32){req_wdata[31:0]}};
      end
      default: begin
        acc_misal = |req_addr[2:0];
        acc_be    = '1;
        acc_wdata = req_wdata;
      end
    endcase
  end

  // Extract the addressed lane from the read word and extend it per op
  always_comb begin
    lane = mem_rdata >> {off_q, 3'b000};
    unique case (op_q[1:0])
      2'b00:   load_data = op_q[2] ? XLEN'(lane[7:0])  : XLEN'($signed(lane[7:0]));
      2'b01:   load_data = op_q[2] ? XLEN'(lane[15:0]) : XLEN'($signed(lane[15:0]));
      2'b10:   load_data = op_q[2] ? XLEN'(lane[31:0]) : XLEN'($signed(lane[31:0]));
      default: load_data = lane;
    endcase
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d      = state_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_be_d     = mem_be_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    op_d         = op_q;
    off_d        = off_q;
`ifdef LSU_TIMEOUT_EN
    cnt_d        = cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          op_d  = req_op;
          off_d = acc_off;
          if (acc_illegal || acc_misal) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_rdata_d = '0;
          end else begin
            state_d     = REQ;
            mem_req_d   = 1'b1;
            mem_we_d    = req_we;
            mem_addr_d  = {req_addr[ADDR_W-1:OFF_W], OFF_W'(0)};
            mem_be_d    = acc_be;
            mem_wdata_d = acc_wdata;
`ifdef LSU_TIMEOUT_EN
            cnt_d       = '0;
`endif
          end
        end
      end
      REQ: begin
        if (mem_ack) begin
          state_d      = RESP;
          mem_req_d    = 1'b0;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b0;
          resp_rdata_d = mem_we_q ? '0 : load_data;
        end
`ifdef LSU_TIMEOUT_EN
        else if (cnt_q == CNT_W'(MAX_WAIT - 1)) begin
          state_d      = RESP;
          mem_req_d    = 1'b0;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b1;
          resp_rdata_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_be_q     <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
      op_q         <= '0;
      off_q        <= '0;
    end else begin
      state_q      <= state_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_be_q     <= mem_be_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
      op_q         <= op_d;
      off_q        <= off_d;
    end
  end

`ifdef LSU_TIMEOUT_EN
  // REQ wait counter
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
`endif

endmodule

// File: tb/tb_lsu_mem_unit.sv
// Testbench for lsu_mem_unit (XLEN = 32, MAX_WAIT = 4): directed scenarios
// plus randomized transactions checked against an arithmetic reference model.
module tb_lsu_mem_unit;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        busy;

  int n_checks;
  int n_fail;

  typedef struct {
    int          req_cycles;
    logic [31:0] maddr;
    logic [3:0]  mbe;
    logic [31:0] mwdata;
    logic        mwe;
    bit          unstable;
    int          resp_cnt;
    int          resp_at;
    logic        rerr;
    logic [31:0] rdata;
  } obs_t;

  lsu_mem_unit #(.XLEN(32), .ADDR_W(32), .MAX_WAIT(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Reference: what the unit should do for one request, from the op/address rules
  function automatic void ref_model(input bit we, input bit [2:0] op, input bit [31:0] addr,
      input bit [31:0] wdata, input bit [31:0] rdata, output bit err, output bit [31:0] eaddr,
      output bit [3:0] ebe, output bit [31:0] ewdata, output bit [31:0] erdata);
    longint unsigned size, off, span, unit, v;
    size   = 64'd1 << op[1:0];
    off    = 64'(addr % 4);
    eaddr  = addr - 32'(off);
    ebe    = '0;
    ewdata = '0;
    erdata = '0;
    err = (op == 3'b111) || (op == 3'b011) || (op == 3'b110) || (we && op[2]) ||
          (64'(addr) % size != 0);
    if (err) return;
    ebe  = 4'(((64'd1 << size) - 1) << off);
    span = 64'd1 << (8 * size);
    unit = 64'(wdata) % span;
    for (int i = 0; i < 4; i += int'(size)) ewdata |= 32'(unit << (8 * i));
    v = (64'(rdata) >> (8 * off)) % span;
    if (!op[2] && v >= span / 2) v = v + (64'd1 << 32) - span;
    erdata = we ? 32'd0 : 32'(v);
  endfunction

  // Drive one request, act as memory (ack after ack_after idle REQ cycles), record what happened
  task automatic run_txn(input bit we, input bit [2:0] op, input bit [31:0] addr,
      input bit [31:0] wdata, input bit [31:0] rdata, input int ack_after, output obs_t o);
    int waitc;
    o.req_cycles = 0; o.maddr = '0; o.mbe = '0; o.mwdata = '0; o.mwe = 1'b0;
    o.unstable = 1'b0; o.resp_cnt = 0; o.resp_at = -1; o.rerr = 1'b0; o.rdata = '0;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_op = op; req_addr = addr; req_wdata = wdata;
    mem_ack = 1'b0;
    waitc = 0;
    while (!req_ready && waitc < 20) begin
      @(negedge clk);
      waitc++;
    end
    if (!req_ready) begin
      req_valid = 1'b0;
      return;
    end
    @(negedge clk);
    req_valid = 1'b0;
    for (int c = 0; c < 60; c++) begin
      if (mem_req) begin
        if (o.req_cycles == 0) begin
          o.maddr = mem_addr; o.mbe = mem_be; o.mwdata = mem_wdata; o.mwe = mem_we;
        end else if (mem_addr !== o.maddr || mem_be !== o.mbe || mem_wdata !== o.mwdata ||
                     mem_we !== o.mwe) begin
          o.unstable = 1'b1;
        end
        o.req_cycles++;
        mem_ack   = (o.req_cycles == ack_after + 1);
        mem_rdata = mem_ack ? rdata : $urandom();
      end else begin
        mem_ack = 1'b0;
      end
      if (resp_valid) begin
        if (o.resp_cnt == 0) begin
          o.resp_at = c; o.rerr = resp_err; o.rdata = resp_rdata;
        end
        o.resp_cnt++;
      end
      if (!busy) break;
      @(negedge clk);
    end
    mem_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({req_ready, busy} !== 2'b00) begin
      n_fail++; $display("FAIL reset_ready_busy: got %b expected 00", {req_ready, busy});
    end
    n_checks++;
    if ({mem_req, mem_we, mem_be, resp_valid, resp_err} !== 8'h00) begin
      n_fail++; $display("FAIL reset_ctrl: got %h expected 00",
                         {mem_req, mem_we, mem_be, resp_valid, resp_err});
    end
    n_checks++;
    if ({mem_addr, mem_wdata, resp_rdata} !== 96'h0) begin
      n_fail++; $display("FAIL reset_data: got %h expected 0", {mem_addr, mem_wdata, resp_rdata});
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if (req_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_release_ready: got %b expected 1", req_ready);
    end
  endtask

  task automatic test_store_byte();
    obs_t o;
    run_txn(1'b1, 3'b000, 32'h0000_1003, 32'hAABB_CCDD, 32'h0, 2, o);
    n_checks++;
    if (o.maddr !== 32'h0000_1000) begin
      n_fail++; $display("FAIL sb_addr: got %h expected 00001000", o.maddr);
    end
    n_checks++;
    if (o.mbe !== 4'b1000) begin
      n_fail++; $display("FAIL sb_be: got %b expected 1000", o.mbe);
    end
    n_checks++;
    if (o.mwdata !== 32'hDDDD_DDDD || o.mwe !== 1'b1) begin
      n_fail++; $display("FAIL sb_wdata_we: got %h/%b expected DDDDDDDD/1", o.mwdata, o.mwe);
    end
    n_checks++;
    if (o.req_cycles !== 3 || o.unstable) begin
      n_fail++; $display("FAIL sb_req_cycles: got %0d unstable=%0d expected 3 stable",
                         o.req_cycles, o.unstable);
    end
    n_checks++;
    if (o.resp_cnt !== 1 || o.resp_at !== 3 || o.rerr !== 1'b0 || o.rdata !== 32'h0) begin
      n_fail++; $display("FAIL sb_resp: got cnt=%0d at=%0d err=%b data=%h expected 1/3/0/0",
                         o.resp_cnt, o.resp_at, o.rerr, o.rdata);
    end
  endtask

  task automatic test_load_ext();
    bit [2:0]  ops  [3] = '{3'b000, 3'b100, 3'b101};
    bit [31:0] exps [3] = '{32'hFFFF_FFF0, 32'h0000_00F0, 32'h0000_12F0};
    bit [3:0]  bes  [3] = '{4'b0100, 4'b0100, 4'b1100};
    obs_t o;
    for (int i = 0; i < 3; i++) begin
      run_txn(1'b0, ops[i], 32'h0000_2002, 32'h0, 32'h12F0_3456, 0, o);
      n_checks++;
      if (o.rdata !== exps[i] || o.rerr !== 1'b0) begin
        n_fail++; $display("FAIL load_ext op=%b: got %h err=%b expected %h err=0",
                           ops[i], o.rdata, o.rerr, exps[i]);
      end
      n_checks++;
      if (o.mbe !== bes[i] || o.maddr !== 32'h0000_2000 || o.mwe !== 1'b0) begin
        n_fail++; $display("FAIL load_mem op=%b: got be=%b addr=%h we=%b expected %b/00002000/0",
                           ops[i], o.mbe, o.maddr, o.mwe, bes[i]);
      end
      n_checks++;
      if (o.req_cycles !== 1 || o.resp_at !== 1 || o.resp_cnt !== 1) begin
        n_fail++; $display("FAIL load_latency op=%b: got req=%0d at=%0d cnt=%0d expected 1/1/1",
                           ops[i], o.req_cycles, o.resp_at, o.resp_cnt);
      end
    end
  endtask

  task automatic test_errors();
    bit        wes   [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    bit [2:0]  ops   [6] = '{3'b010, 3'b011, 3'b111, 3'b110, 3'b100, 3'b001};
    bit [31:0] addrs [6] = '{32'h2002, 32'h2000, 32'h2000, 32'h2000, 32'h2000, 32'h2001};
    obs_t o;
    for (int i = 0; i < 6; i++) begin
      run_txn(wes[i], ops[i], addrs[i], 32'h1234_5678, 32'hFFFF_FFFF, 0, o);
      n_checks++;
      if (o.req_cycles !== 0 || o.resp_at !== 0 || o.resp_cnt !== 1 ||
          o.rerr !== 1'b1 || o.rdata !== 32'h0) begin
        n_fail++; $display("FAIL err_case%0d: got req=%0d at=%0d cnt=%0d err=%b data=%h expected 0/0/1/1/0",
                           i, o.req_cycles, o.resp_at, o.resp_cnt, o.rerr, o.rdata);
      end
    end
  endtask

`ifdef LSU_TIMEOUT_EN
  task automatic test_timeout();
    obs_t o;
    run_txn(1'b0, 3'b010, 32'h0000_3000, 32'h0, 32'hCAFE_F00D, 1000, o);
    n_checks++;
    if (o.req_cycles !== 4 || o.resp_cnt !== 1 || o.rerr !== 1'b1 || o.rdata !== 32'h0) begin
      n_fail++; $display("FAIL timeout: got req=%0d cnt=%0d err=%b data=%h expected 4/1/1/0",
                         o.req_cycles, o.resp_cnt, o.rerr, o.rdata);
    end
    run_txn(1'b0, 3'b010, 32'h0000_3000, 32'h0, 32'hCAFE_F00D, 3, o);
    n_checks++;
    if (o.req_cycles !== 4 || o.resp_cnt !== 1 || o.rerr !== 1'b0 || o.rdata !== 32'hCAFE_F00D) begin
      n_fail++; $display("FAIL timeout_ack_wins: got req=%0d cnt=%0d err=%b data=%h expected 4/1/0/CAFEF00D",
                         o.req_cycles, o.resp_cnt, o.rerr, o.rdata);
    end
  endtask
`endif

  task automatic test_reset_abort();
    int stray;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_op = 3'b010; req_addr = 32'h0000_4000;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (mem_req !== 1'b1 || busy !== 1'b1) begin
      n_fail++; $display("FAIL abort_in_req: got mem_req=%b busy=%b expected 1/1", mem_req, busy);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if (req_ready !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL abort_during_rst: got ready=%b busy=%b expected 0/0", req_ready, busy);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++;
    if (mem_req !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      n_fail++; $display("FAIL abort_after_rst: got req=%b busy=%b ready=%b rv=%b expected 0/0/1/0",
                         mem_req, busy, req_ready, resp_valid);
    end
    stray = 0;
    @(negedge clk);
    mem_ack = 1'b1; mem_rdata = 32'h5555_AAAA;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (resp_valid || mem_req || busy) stray++;
    end
    n_checks++;
    if (stray !== 0) begin
      n_fail++; $display("FAIL abort_late_ack: got %0d stray active cycles expected 0", stray);
    end
  endtask

  task automatic test_back_to_back();
    int          acc_c [$];
    int          resp_c [$];
    logic [31:0] resp_d [$];
    bit [31:0]   rd [2] = '{32'h8081_8283, 32'hBEEF_1234};
    bit          e_err;
    bit [31:0]   e_addr, e_wd, e_rd0, e_rd1;
    bit [3:0]    e_be;
    int          ready_busy;
    bit          upd;
    ref_model(1'b0, 3'b000, 32'h3001, 32'h0, rd[0], e_err, e_addr, e_be, e_wd, e_rd0);
    ref_model(1'b0, 3'b101, 32'h3002, 32'h0, rd[1], e_err, e_addr, e_be, e_wd, e_rd1);
    ready_busy = 0;
    upd = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_op = 3'b000; req_addr = 32'h0000_3001;
    for (int c = 0; c < 20; c++) begin
      if (upd) begin
        upd = 1'b0;
        if (acc_c.size() == 1) begin
          req_op = 3'b101; req_addr = 32'h0000_3002;
        end else begin
          req_valid = 1'b0;
        end
      end
      if (busy && req_ready) ready_busy++;
      if (req_valid && req_ready) begin
        acc_c.push_back(c);
        upd = 1'b1;
      end
      mem_ack   = mem_req;
      mem_rdata = (acc_c.size() >= 1) ? rd[acc_c.size() - 1] : 32'h0;
      if (resp_valid) begin
        resp_c.push_back(c);
        resp_d.push_back(resp_rdata);
      end
      @(negedge clk);
    end
    mem_ack = 1'b0;
    req_valid = 1'b0;
    n_checks++;
    if (acc_c.size() != 2 || acc_c[1] - acc_c[0] != 3) begin
      n_fail++; $display("FAIL b2b_accept: got %0d accepts, spacing %0d expected 2 spaced 3",
                         acc_c.size(), (acc_c.size() == 2) ? acc_c[1] - acc_c[0] : -1);
    end
    n_checks++;
    if (resp_c.size() != 2 || resp_d[0] !== e_rd0 || resp_d[1] !== e_rd1) begin
      n_fail++; $display("FAIL b2b_resp: got %0d pulses data %h %h expected 2 pulses %h %h",
                         resp_c.size(), (resp_d.size() > 0) ? resp_d[0] : 32'hx,
                         (resp_d.size() > 1) ? resp_d[1] : 32'hx, e_rd0, e_rd1);
    end
    n_checks++;
    if (ready_busy != 0) begin
      n_fail++; $display("FAIL b2b_ready_busy: got %0d cycles ready while busy expected 0", ready_busy);
    end
  endtask

  task automatic test_random();
    obs_t      o;
    bit        we, e_err;
    bit [2:0]  op;
    bit [31:0] addr, wd, rd, e_addr, e_wd, e_rd;
    bit [3:0]  e_be;
    int        d;
    for (int n = 0; n < 60; n++) begin
      we   = 1'($urandom_range(0, 1));
      op   = 3'($urandom_range(0, 7));
      addr = {$urandom(), 3'b000} | 32'($urandom_range(0, 7));
      wd   = $urandom();
      rd   = $urandom();
      d    = $urandom_range(0, 3);
      ref_model(we, op, addr, wd, rd, e_err, e_addr, e_be, e_wd, e_rd);
      run_txn(we, op, addr, wd, rd, d, o);
      n_checks++;
      if (o.resp_cnt !== 1 || o.rerr !== e_err || o.rdata !== e_rd) begin
        n_fail++; $display("FAIL rnd%0d_resp we=%b op=%b addr=%h: got cnt=%0d err=%b data=%h expected 1/%b/%h",
                           n, we, op, addr, o.resp_cnt, o.rerr, o.rdata, e_err, e_rd);
      end
      n_checks++;
      if (o.req_cycles !== (e_err ? 0 : d + 1) || o.resp_at !== (e_err ? 0 : d + 1)) begin
        n_fail++; $display("FAIL rnd%0d_timing: got req=%0d at=%0d expected %0d/%0d",
                           n, o.req_cycles, o.resp_at, e_err ? 0 : d + 1, e_err ? 0 : d + 1);
      end
      if (!e_err) begin
        n_checks++;
        if (o.maddr !== e_addr || o.mbe !== e_be || o.mwe !== we || o.unstable ||
            (we && o.mwdata !== e_wd)) begin
          n_fail++; $display("FAIL rnd%0d_mem: got addr=%h be=%b we=%b wd=%h unstable=%0d expected %h/%b/%b/%h/0",
                             n, o.maddr, o.mbe, o.mwe, o.mwdata, o.unstable, e_addr, e_be, we, e_wd);
        end
      end
    end
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_op    = 3'b000;
    req_addr  = '0;
    req_wdata = '0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    test_reset();
    test_store_byte();
    test_load_ext();
    test_errors();
`ifdef LSU_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_abort();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu_mem_unit.md
Name: lsu_mem_unit

Overview:
- Parametrised load/store unit that replaces the combinational data write/read muxes and the dual-clock data memory glue.
- Accepts one load or store per transaction from the core over a valid/ready handshake.
- Drives a word-addressed data memory with byte enables and a variable-latency ack, then returns a sign- or zero-extended load result or an error.
- Supports XLEN 32 or 64. Stores use byte enables, with no read-modify-write.

Parameters:
XLEN, 32, data width; legal values 32 or 64
ADDR_W, 32, byte-address width
MAX_WAIT, 15, cycles allowed in REQ before timeout (used only with LSU_TIMEOUT_EN)

Ports:
clk  in  1  single clock, all logic on posedge
rst  in  1  synchronous, active-high reset
req_valid  in  1  core presents request
req_ready  out  1  unit can accept request
req_we  in  1  1=store, 0=load
req_op  in  3  RV funct3: 000 b, 001 h, 010 w, 011 d, 100 bu, 101 hu, 110 wu
req_addr  in  ADDR_W  byte address
req_wdata  in  XLEN  store data, low-aligned
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  XLEN  extended load data; 0 for stores and errors
resp_err  out  1  misaligned, illegal op, or timeout; valid with resp_valid
mem_req  out  1  memory request, held until mem_ack
mem_we  out  1  memory write
mem_addr  out  ADDR_W  lane-aligned address; low log2(XLEN/8) bits are 0
mem_wdata  out  XLEN  store data replicated across lanes
mem_be  out  XLEN/8  byte enables
mem_ack  in  1  memory completes this cycle
mem_rdata  in  XLEN  read lane, valid with mem_ack
busy  out  1  state != IDLE

Behaviour:
- FSM states IDLE, REQ, RESP. All outputs are registered except req_ready and busy, which decode directly from state.
- Reset: state IDLE. Forces to 0: mem_req, mem_we, mem_addr, mem_wdata, mem_be, resp_valid, resp_rdata, resp_err. During rst, req_ready = 0 and busy = 0.
- req_ready = (state == IDLE) && !rst. A request is accepted when req_valid && req_ready at a posedge.
- On accept, op and address are checked:
  - Illegal ops: 011/110 when XLEN = 32; 111 always; 100/101/110 with req_we = 1.
  - Misaligned: h with addr[0] != 0; w with addr[1:0] != 0; d with addr[2:0] != 0.
  - Illegal or misaligned → RESP with resp_err = 1 and resp_rdata = 0; mem_req never asserts.
  - Otherwise → REQ with mem_addr, mem_we, mem_be and mem_wdata registered.
- Byte-enable and data rules, with off = addr offset within the lane:
  - mem_be: b = 1<<off; h = 3<<off; w = 0xF<<off; d = all ones.
  - mem_wdata: b replicates byte 0; h replicates half 0; w replicates word 0 (XLEN = 64).
- REQ: mem_req = 1, with all mem_* held stable.
  - On mem_ack, mem_rdata is captured. Loads extract the lane at off and sign-extend (b/h/w) or zero-extend (bu/hu/wu). State → RESP.
  - mem_req drops in the cycle after ack.
- RESP: resp_valid = 1 for exactly one cycle, then IDLE. A new request is accepted in the IDLE cycle after RESP.
- Minimum latency with ack in the first REQ cycle: accept at edge T, mem_req high during T..T+1, resp_valid during T+1..T+2. Three cycles accept-to-accept.
- mem_ack outside REQ is ignored.
- rst asserted in any state returns to IDLE at the next edge: mem_req drops, and no resp_valid is produced for the aborted transaction.

Optional Feature:
- LSU_TIMEOUT_EN defined:
  - A counter clears on entry to REQ and increments each REQ cycle without ack.
  - When the count reaches MAX_WAIT without ack: → RESP with resp_err = 1, resp_rdata = 0, and mem_req dropped.
  - Ack in the same cycle the limit is reached wins: normal completion.
  - Counter width is $clog2(MAX_WAIT+1).
- LSU_TIMEOUT_EN undefined: no counter; REQ waits indefinitely for mem_ack.

Test Plan:
1. XLEN = 32. Store b, addr 0x1003, wdata 0xAABBCCDD, ack after 2 REQ cycles → mem_addr 0x1000, mem_be 4'b1000, mem_wdata 0xDDDDDDDD, mem_we 1; resp_valid 1 cycle, resp_err 0, resp_rdata 0.
2. Load b at 0x2002 with mem_rdata 0x12F03456 → resp_rdata 0xFFFFFFF0. Same with op bu → 0x000000F0. Op hu at 0x2002 → 0x000012F0.
3. Load w at 0x2002; also op 011 with XLEN = 32 → mem_req stays 0; resp_valid one cycle after accept, resp_err 1, resp_rdata 0.
4. LSU_TIMEOUT_EN, MAX_WAIT = 4, mem_ack tied 0 → mem_req high exactly 4 cycles, then resp_err 1. Repeat with ack in the 4th cycle → normal completion, err 0.
5. rst pulsed during the 2nd REQ cycle, then a late mem_ack → next cycle mem_req 0, busy 0, req_ready 1 after rst release; no resp_valid; late ack ignored.
6. req_valid held high with two loads back-to-back, immediate ack → accepts 3 cycles apart; two resp_valid pulses with the correct data; req_ready low while busy.
